branch_ctrl_sequencer: RTL and testbench
========================================

Name: branch_ctrl_sequencer

Overview:
Hardwired control-step sequencer that replaces hand-driven bench control for the fetch, ldi and conditional-branch (brzr/brnz/brpl/brmi) sequences. It drives the existing datapath/System control inputs and supports memory wait states via memory_done, a fetch timeout, single-step mode, and halt/illegal-opcode trapping. It is parametrised in opcode encodings, wait timeout and instruction-counter width. It sits between IR/CON_FF status and the System control port list.

Parameters:
OPCODE_WIDTH, 5, width of ir_opcode and alu_opcode
OP_LDI, 5'b00001, ldi opcode
OP_BR, 5'b10011, branch-class opcode (condition is in C2, evaluated by CON_FF)
OP_NOP, 5'b11010, no-operation
OP_HALT, 5'b11011, halt
ALU_ADD, 5'b00011, ALU add code driven on alu_opcode
MEM_TIMEOUT, 15, maximum T1 cycles waiting for memory_done before trapping
COUNT_WIDTH, 16, width of instr_count

Ports:
Clock  in  1  system clock; all state changes on rising edge
clear  in  1  asynchronous, active-low reset
run  in  1  level; leaves IDLE when high
step_mode  in  1  1 = pause in STEP_WAIT after each instruction
step  in  1  single-cycle pulse; releases STEP_WAIT
ir_opcode  in  OPCODE_WIDTH  IR[31:27]; valid from T3 onward
con_ff_bit  in  1  CON_FF output
memory_done  in  1  memory read complete
PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout, CONin  out  1 each  datapath controls
alu_opcode  out  OPCODE_WIDTH  ALU operation; ALU_ADD in add steps, else 0
busy  out  1  high in any state except IDLE/HALTED/ERROR
halted  out  1  high in HALTED
illegal_op  out  1  high in ERROR
branch_taken  out  1  one-cycle pulse in BR_T6 when con_ff_bit=1
instr_count  out  COUNT_WIDTH  completed-instruction count

Behaviour:
- Reset (clear=0, any time, including mid-instruction): state=IDLE; all outputs 0; instr_count=0; wait counter=0.
- Outputs are Moore-decoded from the state register. The only exception is PCin in BR_T6, which equals con_ff_bit combinationally.
- IDLE: all controls 0. Move to T0 when run=1.
- T0: PCout, IncPC, MARin, Zin = 1. Next state is T1.
- T1: Zlo_out, MDRin, Mem_Read, Mem_enable512x32 = 1 while in T1.
  - PCin=1 only in the first T1 cycle.
  - Stay in T1 until memory_done=1, then go to T2. memory_done high in the first T1 cycle means zero wait.
  - Wait counter counts T1 cycles. If MEM_TIMEOUT cycles elapse without memory_done, go to ERROR.
- T2: MDRout, IRin = 1. Next state is T3.
- T3 decode, on ir_opcode:
  - OP_LDI: Grb, BAout, Yin = 1. Then LDI_T4: Cout, Zin = 1, alu_opcode=ALU_ADD. Then LDI_T5: Zlo_out, Gra, Rin = 1. Instruction ends.
  - OP_BR: Gra, Rout, CONin = 1. Then BR_T4: PCout, Yin = 1. Then BR_T5: Cout, Zin = 1, alu_opcode=ALU_ADD. Then BR_T6: Zlo_out=1, PCin=con_ff_bit, branch_taken=con_ff_bit. Instruction ends.
  - OP_NOP: no controls. Instruction ends in T3.
  - OP_HALT: go to HALTED.
  - Any other opcode: go to ERROR.
- Instruction end: instr_count increments (wraps modulo 2^COUNT_WIDTH). Next state is STEP_WAIT if step_mode=1, else T0.
- STEP_WAIT: all controls 0, busy=1. Go to T0 on step=1. If step_mode is deasserted while waiting, go to T0 on the next cycle.
- run is sampled only in IDLE. Dropping run mid-instruction has no effect.
- HALTED and ERROR are absorbing; only reset exits them. instr_count holds.
- HALT and illegal opcodes do not increment instr_count.
- Fetch latency with zero wait: 3 cycles. Instruction totals: ldi 6 cycles, br 7 cycles, nop 4 cycles, plus any T1 wait cycles.

Test Plan:
- Reset mid-fetch: drop clear during T1 with Mem_Read=1 -> all controls 0 the same cycle; state=IDLE, instr_count=0; after release and run=1, T0 follows on the next edge.
- ldi flow, memory_done tied 1, ir_opcode=00001 -> 6-cycle control sequence exactly as specified; alu_opcode=00011 only in LDI_T4; instr_count 0 -> 1.
- Branch taken/not taken: ir_opcode=10011, con_ff_bit=1 -> PCin and branch_taken high in BR_T6. Repeat with con_ff_bit=0 -> PCin=0 in BR_T6. Both take 7 cycles.
- Wait states: memory_done asserted in the 3rd T1 cycle -> T1 lasts 3 cycles, PCin high only in the first. memory_done never asserted -> ERROR after 15 cycles, illegal_op=1.
- Step mode: step_mode=1, two nops -> STEP_WAIT after each; T0 follows the cycle after a step pulse; instr_count=2.
- Trapping: ir_opcode=11011 -> halted=1, busy=0, controls 0 and held until reset. ir_opcode=00111 -> illegal_op=1, instr_count unchanged.

Source files
------------

// File: rtl/branch_ctrl_sequencer.sv
// Purpose : hardwired control-step sequencer for fetch, ldi and conditional branch (brzr/brnz/brpl/brmi).
// Latency : fetch is 3 cycles plus memory wait cycles; ldi 6, br 7, nop 4 cycles in total.
// Stall   : holds in T1 until memory_done (traps after MEM_TIMEOUT cycles); pauses in STEP_WAIT in step mode.
module branch_ctrl_sequencer #(
   parameter int                      OPCODE_WIDTH = 5,
   parameter logic [OPCODE_WIDTH-1:0] OP_LDI       = 5'b00001,
   parameter logic [OPCODE_WIDTH-1:0] OP_BR        = 5'b10011,
   parameter logic [OPCODE_WIDTH-1:0] OP_NOP       = 5'b11010,
   parameter logic [OPCODE_WIDTH-1:0] OP_HALT      = 5'b11011,
   parameter logic [OPCODE_WIDTH-1:0] ALU_ADD      = 5'b00011,
   parameter int                      MEM_TIMEOUT  = 15,
   parameter int                      COUNT_WIDTH  = 16
) (
   input  logic                    Clock,
   input  logic                    clear,
   input  logic                    run,
   input  logic                    step_mode,
   input  logic                    step,
   input  logic [OPCODE_WIDTH-1:0] ir_opcode,
   input  logic                    con_ff_bit,
   input  logic                    memory_done,
   output logic                    PCout,
   output logic                    IncPC,
   output logic                    MARin,
   output logic                    Zin,
   output logic                    Zlo_out,
   output logic                    PCin,
   output logic                    MDRin,
   output logic                    Mem_Read,
   output logic                    Mem_enable512x32,
   output logic                    MDRout,
   output logic                    IRin,
   output logic                    Gra,
   output logic                    Grb,
   output logic                    Rin,
   output logic                    Rout,
   output logic                    BAout,
   output logic                    Yin,
   output logic                    Cout,
   output logic                    CONin,
   output logic [OPCODE_WIDTH-1:0] alu_opcode,
   output logic                    busy,
   output logic                    halted,
   output logic                    illegal_op,
   output logic                    branch_taken,
   output logic [COUNT_WIDTH-1:0]  instr_count
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3,
      S_LDI_T4, S_LDI_T5,
      S_BR_T4, S_BR_T5, S_BR_T6,
      S_STEP_WAIT, S_HALTED, S_ERROR
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   state_t                 w_after_end;
   logic [WAIT_W-1:0]      r_wait_cnt;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   w_last_wait;
   logic                   w_instr_end;

   // r_wait_cnt holds the number of T1 cycles already spent, so zero marks the first T1 cycle
   assign w_last_wait = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign w_instr_end = ((r_state == S_T3) && (ir_opcode == OP_NOP)) ||
                        (r_state == S_LDI_T5) || (r_state == S_BR_T6);
   assign w_after_end = step_mode ? S_STEP_WAIT : S_T0;
   assign instr_count = r_count;

   // State register
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Memory wait counter: advances every T1 cycle, cleared everywhere else
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear)                r_wait_cnt <= '0;
      else if (r_state == S_T1)  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else                       r_wait_cnt <= '0;
   end

   // Completed-instruction counter, wraps naturally; traps never count
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear)           r_count <= '0;
      else if (w_instr_end) r_count <= r_count + COUNT_WIDTH'(1);
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (run) w_next = S_T0;
         S_T0:        w_next = S_T1;
         S_T1: begin
            if (memory_done)      w_next = S_T2;
            else if (w_last_wait) w_next = S_ERROR;
         end
         S_T2:        w_next = S_T3;
         S_T3: begin
            case (ir_opcode)
               OP_LDI:  w_next = S_LDI_T4;
               OP_BR:   w_next = S_BR_T4;
               OP_NOP:  w_next = w_after_end;
               OP_HALT: w_next = S_HALTED;
               default: w_next = S_ERROR;
            endcase
         end
         S_LDI_T4:    w_next = S_LDI_T5;
         S_LDI_T5:    w_next = w_after_end;
         S_BR_T4:     w_next = S_BR_T5;
         S_BR_T5:     w_next = S_BR_T6;
         S_BR_T6:     w_next = w_after_end;
         S_STEP_WAIT: if (step || !step_mode) w_next = S_T0;
         S_HALTED:    w_next = S_HALTED;
         S_ERROR:     w_next = S_ERROR;
         default:     w_next = S_IDLE;
      endcase
   end

   // Control decode; T3 looks at the freshly loaded opcode, BR_T6 forwards the CON_FF result
   always_comb begin
      PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; Zin = 1'b0; Zlo_out = 1'b0;
      PCin = 1'b0; MDRin = 1'b0; Mem_Read = 1'b0; Mem_enable512x32 = 1'b0;
      MDRout = 1'b0; IRin = 1'b0; Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0;
      BAout = 1'b0; Yin = 1'b0; Cout = 1'b0; CONin = 1'b0;
      alu_opcode = '0; branch_taken = 1'b0;
      busy       = !((r_state == S_IDLE) || (r_state == S_HALTED) || (r_state == S_ERROR));
      halted     = (r_state == S_HALTED);
      illegal_op = (r_state == S_ERROR);
      case (r_state)
         S_T0: begin
            PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
         end
         S_T1: begin
            Zlo_out = 1'b1; MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
            PCin    = (r_wait_cnt == '0);
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            if (ir_opcode == OP_LDI) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (ir_opcode == OP_BR) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end
         end
         S_LDI_T4, S_BR_T5: begin
            Cout = 1'b1; Zin = 1'b1; alu_opcode = ALU_ADD;
         end
         S_LDI_T5: begin
            Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
         end
         S_BR_T4: begin
            PCout = 1'b1; Yin = 1'b1;
         end
         S_BR_T6: begin
            Zlo_out      = 1'b1;
            PCin         = con_ff_bit;
            branch_taken = con_ff_bit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_branch_ctrl_sequencer.sv
// Purpose : self-checking bench for branch_ctrl_sequencer, directed cases plus randomized instruction streams.
// Latency : expected control words are produced one per cycle from the instruction step tables below.
// Stall   : memory wait length, step mode and step pulses are chosen per instruction.
module tb_branch_ctrl_sequencer;

   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] OP_BAD  = 5'b00111;

   // Observed word layout: {19 datapath controls, busy, halted, illegal_op, branch_taken, alu_opcode}
   localparam logic [27:0] B_PCOUT = 28'd1 << 27;
   localparam logic [27:0] B_INCPC = 28'd1 << 26;
   localparam logic [27:0] B_MARIN = 28'd1 << 25;
   localparam logic [27:0] B_ZIN   = 28'd1 << 24;
   localparam logic [27:0] B_ZLO   = 28'd1 << 23;
   localparam logic [27:0] B_PCIN  = 28'd1 << 22;
   localparam logic [27:0] B_MDRIN = 28'd1 << 21;
   localparam logic [27:0] B_MRD   = 28'd1 << 20;
   localparam logic [27:0] B_MEN   = 28'd1 << 19;
   localparam logic [27:0] B_MDROUT= 28'd1 << 18;
   localparam logic [27:0] B_IRIN  = 28'd1 << 17;
   localparam logic [27:0] B_GRA   = 28'd1 << 16;
   localparam logic [27:0] B_GRB   = 28'd1 << 15;
   localparam logic [27:0] B_RIN   = 28'd1 << 14;
   localparam logic [27:0] B_ROUT  = 28'd1 << 13;
   localparam logic [27:0] B_BAOUT = 28'd1 << 12;
   localparam logic [27:0] B_YIN   = 28'd1 << 11;
   localparam logic [27:0] B_COUT  = 28'd1 << 10;
   localparam logic [27:0] B_CONIN = 28'd1 << 9;
   localparam logic [27:0] B_BUSY  = 28'd1 << 8;
   localparam logic [27:0] B_HALT  = 28'd1 << 7;
   localparam logic [27:0] B_ILL   = 28'd1 << 6;
   localparam logic [27:0] B_BT    = 28'd1 << 5;
   localparam logic [27:0] B_ADD   = 28'h0000003;

   localparam logic [27:0] W_T0  = B_PCOUT | B_INCPC | B_MARIN | B_ZIN | B_BUSY;
   localparam logic [27:0] W_T1  = B_ZLO | B_MDRIN | B_MRD | B_MEN | B_BUSY;
   localparam logic [27:0] W_T2  = B_MDROUT | B_IRIN | B_BUSY;
   localparam logic [27:0] W_ADD = B_COUT | B_ZIN | B_ADD | B_BUSY;

   logic        Clock, clear, run, step_mode, step, con_ff_bit, memory_done;
   logic [4:0]  ir_opcode;
   logic        PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32;
   logic        MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout, CONin;
   logic [4:0]  alu_opcode;
   logic        busy, halted, illegal_op, branch_taken;
   logic [15:0] instr_count;
   logic [27:0] obs;

   int          n_chk;
   int          n_fail;
   logic [15:0] exp_count;

   branch_ctrl_sequencer dut (
      .Clock(Clock), .clear(clear), .run(run), .step_mode(step_mode), .step(step),
      .ir_opcode(ir_opcode), .con_ff_bit(con_ff_bit), .memory_done(memory_done),
      .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
      .PCin(PCin), .MDRin(MDRin), .Mem_Read(Mem_Read), .Mem_enable512x32(Mem_enable512x32),
      .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .Yin(Yin), .Cout(Cout), .CONin(CONin), .alu_opcode(alu_opcode),
      .busy(busy), .halted(halted), .illegal_op(illegal_op), .branch_taken(branch_taken),
      .instr_count(instr_count)
   );

   assign obs = {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32,
                 MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout, CONin,
                 busy, halted, illegal_op, branch_taken, alu_opcode};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed time-out, required end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [27:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic chk_count(input string tag);
      n_chk++;
      assert (instr_count === exp_count) else begin
         n_fail++;
         $error("FAIL %s count: observed %0d required %0d", tag, instr_count, exp_count);
      end
   endtask

   // One clock: compare the current cycle's outputs away from the edge, then advance
   task automatic cyc(input string tag, input logic [27:0] exp);
      @(negedge Clock);
      chk(tag, exp);
      @(posedge Clock);
      #1;
   endtask

   task automatic scramble();
      run         = 1'($urandom_range(0, 1));
      step        = 1'($urandom_range(0, 1));
      step_mode   = 1'($urandom_range(0, 1));
      con_ff_bit  = 1'($urandom_range(0, 1));
      memory_done = 1'($urandom_range(0, 1));
      ir_opcode   = 5'($urandom_range(0, 31));
   endtask

   // Asynchronous reset applied mid-cycle, released with run high; returns in T0
   task automatic do_reset(input string tag);
      clear = 1'b0;
      exp_count = '0;
      #1;
      chk({tag, "_async"}, 28'd0);
      chk_count(tag);
      @(negedge Clock);
      clear = 1'b1; run = 1'b1; step = 1'b0; step_mode = 1'b0; memory_done = 1'b0;
      chk({tag, "_idle"}, 28'd0);
      @(posedge Clock);
      #1;
   endtask

   // Reference model for one instruction starting in T0. waits = T1 cycle in which
   // memory_done rises (outside 1..15 means never). Traps leave the DUT absorbed.
   task automatic run_instr(input logic [4:0] op, input int waits, input bit con,
                            input bit smode, input bit drop);
      ir_opcode = op; step_mode = smode; step = 1'b0; memory_done = 1'b0;
      run = 1'($urandom_range(0, 1));
      con_ff_bit = 1'($urandom_range(0, 1));
      chk_count("T0");
      cyc("T0", W_T0);
      for (int k = 1; k <= 15; k++) begin
         memory_done = (k == waits);
         cyc("T1", W_T1 | ((k == 1) ? B_PCIN : 28'd0));
         if (k == waits) break;
      end
      memory_done = 1'b0;
      if (waits < 1 || waits > 15) begin
         for (int i = 0; i < 3; i++) begin
            scramble();
            cyc("TIMEOUT_ERR", B_ILL);
            chk_count("TIMEOUT_ERR");
         end
         return;
      end
      cyc("T2", W_T2);
      case (op)
         OP_LDI: begin
            cyc("LDI_T3", B_GRB | B_BAOUT | B_YIN | B_BUSY);
            cyc("LDI_T4", W_ADD);
            cyc("LDI_T5", B_ZLO | B_GRA | B_RIN | B_BUSY);
            exp_count++;
         end
         OP_BR: begin
            cyc("BR_T3", B_GRA | B_ROUT | B_CONIN | B_BUSY);
            cyc("BR_T4", B_PCOUT | B_YIN | B_BUSY);
            cyc("BR_T5", W_ADD);
            con_ff_bit = con;
            cyc("BR_T6", B_ZLO | B_BUSY | (con ? (B_PCIN | B_BT) : 28'd0));
            exp_count++;
         end
         OP_NOP: begin
            cyc("NOP_T3", B_BUSY);
            exp_count++;
         end
         default: begin
            cyc("TRAP_T3", B_BUSY);
            for (int i = 0; i < 3; i++) begin
               scramble();
               cyc((op == OP_HALT) ? "HALTED" : "ILLEGAL", (op == OP_HALT) ? B_HALT : B_ILL);
               chk_count("TRAP");
            end
            return;
         end
      endcase
      if (smode) begin
         repeat ($urandom_range(0, 2)) cyc("STEP_WAIT", B_BUSY);
         if (drop) step_mode = 1'b0;
         else      step = 1'b1;
         cyc("STEP_REL", B_BUSY);
         step = 1'b0;
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; exp_count = '0;
      clear = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0;
      con_ff_bit = 1'b0; memory_done = 1'b0; ir_opcode = '0;

      // Power-on reset and IDLE holding while run is low
      repeat (2) @(posedge Clock);
      #1;
      chk("reset", 28'd0);
      chk_count("reset");
      clear = 1'b1;
      cyc("idle0", 28'd0);
      cyc("idle1", 28'd0);
      run = 1'b1;
      cyc("idle_run", 28'd0);

      // Reset dropped while T1 is waiting on memory
      ir_opcode = OP_LDI;
      memory_done = 1'b0;
      cyc("mf_T0", W_T0);
      cyc("mf_T1a", W_T1 | B_PCIN);
      chk("mf_T1b", W_T1);
      do_reset("midfetch");

      // Directed flows
      run_instr(OP_LDI, 1, 1'b0, 1'b0, 1'b0);
      run_instr(OP_BR,  1, 1'b1, 1'b0, 1'b0);
      run_instr(OP_BR,  1, 1'b0, 1'b0, 1'b0);
      run_instr(OP_LDI, 3, 1'b0, 1'b0, 1'b0);
      run_instr(OP_BR,  2, 1'b1, 1'b0, 1'b0);

      // Step mode from a clean count: two nops, then a release by dropping step_mode
      do_reset("pre_step");
      run_instr(OP_NOP, 1, 1'b0, 1'b1, 1'b0);
      run_instr(OP_NOP, 1, 1'b0, 1'b1, 1'b0);
      run_instr(OP_NOP, 2, 1'b0, 1'b1, 1'b1);

      // Randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         int sel;
         logic [4:0] op;
         sel = int'($urandom_range(0, 2));
         op  = (sel == 0) ? OP_LDI : ((sel == 1) ? OP_BR : OP_NOP);
         run_instr(op, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end

      // Memory never answers: trap after the full timeout
      run_instr(OP_LDI, 0, 1'b0, 1'b0, 1'b0);
      do_reset("after_timeout");

      // Slowest successful fetch: memory_done on the last allowed T1 cycle
      run_instr(OP_NOP, 15, 1'b0, 1'b0, 1'b0);

      // Halt trap
      run_instr(OP_HALT, 1, 1'b0, 1'b0, 1'b0);
      do_reset("after_halt");

      // Illegal opcode with a non-zero count that must hold
      run_instr(OP_LDI, 1, 1'b0, 1'b0, 1'b0);
      run_instr(OP_BAD, 2, 1'b0, 1'b0, 1'b0);
      do_reset("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
